// File: rtl/top_system.sv
// top_system: four-MAC systolic chain with a weight-load pass, a 4-sample
// MAC pass and a second-layer pass that reuses MAC0/MAC1 results as inputs.
//
// Parameters
//   W       signed activation / weight width
//   ACC_W   signed accumulator width (assumed >= 2*W)
//   N_MACS  MAC chain length (fixed at 4 by the acc_out_0..3 ports)
//
// Ports
//   clk                   rising-edge clock for all state
//   rst                   synchronous active-high reset
//   start_weight          one-cycle request: load weights mode+i+1 into MAC i
//   start_valid_pipeline  one-cycle request: run the 4-sample MAC pass
//   start_layering        one-cycle request: run the second-layer pass
//   mode[2:0]             weight-set selector, sampled on weight-load accept
//   clear_all             synchronous clear/abort (weights and mode kept)
//   busy                  high while an operation is in progress
//   acc_out_0..3          registered accumulators of MAC 0..3
//   valid_out[N_MACS-1:0] bit i pulses one cycle when acc_out_i is final
//
// Build option
//   ACC_SAT_EN  defined: accumulates saturate; undefined: two's-complement wrap
module top_system #(
  parameter int unsigned W      = 8,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned N_MACS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_weight,
  input  logic                    start_valid_pipeline,
  input  logic                    start_layering,
  input  logic [2:0]              mode,
  input  logic                    clear_all,
  output logic                    busy,
  output logic signed [ACC_W-1:0] acc_out_0,
  output logic signed [ACC_W-1:0] acc_out_1,
  output logic signed [ACC_W-1:0] acc_out_2,
  output logic signed [ACC_W-1:0] acc_out_3,
  output logic [N_MACS-1:0]       valid_out
);

  typedef enum logic [1:0] {IDLE, LOAD_W, RUN_V, RUN_L} state_t;

  state_t                  state;
  logic [2:0]              cnt;       // load index / run cycle number
  logic [2:0]              mode_q;
  logic signed [W-1:0]     wt  [4];
  logic signed [W-1:0]     act [4];   // activation seen by MAC i this cycle
  logic [3:0]              act_vld;
  logic signed [ACC_W-1:0] acc [4];
  logic                    run_v;

  assign run_v     = (state == RUN_V);
  assign acc_out_0 = acc[0];
  assign acc_out_1 = acc[1];
  assign acc_out_2 = acc[2];
  assign acc_out_3 = acc[3];

  // Weight for MAC idx: mode+idx+1 taken as a W-bit signed value.
  function automatic logic signed [W-1:0] weight_value(input logic [2:0] m,
                                                       input logic [1:0] idx);
    logic [3:0] v;
    v = 4'(m) + 4'(idx) + 4'd1;
    return W'(v);
  endfunction

  // One accumulate: signed WxW product, sign-extended, added with wrap or clamp.
  function automatic logic signed [ACC_W-1:0] mac_step(
    input logic signed [ACC_W-1:0] acc_in,
    input logic signed [W-1:0]     a,
    input logic signed [W-1:0]     b
  );
    logic signed [2*W-1:0] prod;
    logic signed [ACC_W:0] sum;
    prod = (2*W)'(a) * (2*W)'(b);
    sum  = (ACC_W+1)'(acc_in) + (ACC_W+1)'(prod);
`ifdef ACC_SAT_EN
    if (sum[ACC_W] != sum[ACC_W-1])
      mac_step = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      mac_step = sum[ACC_W-1:0];
`else
    mac_step = sum[ACC_W-1:0];
`endif
  endfunction

  // Control FSM, systolic activation shift and accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mode_q    <= '0;
      busy      <= 1'b0;
      valid_out <= '0;
      act_vld   <= '0;
      for (int i = 0; i < 4; i++) begin
        wt[i]  <= '0;
        act[i] <= '0;
        acc[i] <= '0;
      end
    end else if (clear_all) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      valid_out <= '0;
      act_vld   <= '0;
      for (int i = 0; i < 4; i++) begin
        act[i] <= '0;
        acc[i] <= '0;
      end
    end else begin
      valid_out <= '0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (start_weight) begin
            mode_q <= mode;
            busy   <= 1'b1;
            state  <= LOAD_W;
          end else if (start_valid_pipeline) begin
            // x_0 = 1 is presented to MAC0 during run cycle 0
            for (int i = 0; i < 4; i++) begin
              acc[i] <= '0;
              act[i] <= '0;
            end
            act[0]  <= W'(1);
            act_vld <= 4'b0001;
            busy    <= 1'b1;
            state   <= RUN_V;
          end else if (start_layering) begin
            // a0 goes straight to MAC2; a1 waits one stage in slot 1
            acc[2]  <= '0;
            acc[3]  <= '0;
            act[0]  <= '0;
            act[1]  <= acc[1][W-1:0];
            act[2]  <= acc[0][W-1:0];
            act[3]  <= '0;
            act_vld <= 4'b0110;
            busy    <= 1'b1;
            state   <= RUN_L;
          end
        end

        LOAD_W: begin
          wt[cnt[1:0]] <= weight_value(mode_q, cnt[1:0]);
          cnt          <= cnt + 3'd1;
          if (cnt == 3'd3) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        RUN_V, RUN_L: begin
          act[0]     <= (run_v && cnt < 3'd3) ? W'(cnt + 3'd2) : '0;
          act_vld[0] <= run_v && (cnt < 3'd3);
          for (int i = 1; i < 4; i++) act[i] <= act[i-1];
          act_vld[3:1] <= act_vld[2:0];
          // The layer pass only touches MAC2/MAC3.
          for (int i = 0; i < 4; i++) begin
            if (act_vld[i] && (run_v || i >= 2))
              acc[i] <= mac_step(acc[i], act[i], wt[i]);
          end
          // Flag a MAC on the edge of its last accumulate.
          for (int i = 0; i < 4; i++) begin
            if (run_v)
              valid_out[i] <= (cnt == 3'(3 + i));
            else
              valid_out[i] <= (i >= 2) && (cnt == 3'(i - 1));
          end
          cnt <= cnt + 3'd1;
          if (cnt == (run_v ? 3'd7 : 3'd3)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_top_system.sv
// Self-checking bench for top_system: drives a default instance (W=8, ACC_W=16)
// and a narrow instance (W=4, ACC_W=8) with the same stimulus and compares both
// against an arithmetic reference model of the weight, MAC and layer passes.
module tb_top_system;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start_weight, start_valid_pipeline, start_layering, clear_all;
  logic [2:0] mode;

  logic              busy_a, busy_b;
  logic [3:0]        vo_a, vo_b;
  logic signed [15:0] acc_a0, acc_a1, acc_a2, acc_a3;
  logic signed [7:0]  acc_b0, acc_b1, acc_b2, acc_b3;

  top_system #(.W(8), .ACC_W(16), .N_MACS(4)) dut_a (
    .clk(clk), .rst(rst), .start_weight(start_weight),
    .start_valid_pipeline(start_valid_pipeline), .start_layering(start_layering),
    .mode(mode), .clear_all(clear_all), .busy(busy_a),
    .acc_out_0(acc_a0), .acc_out_1(acc_a1), .acc_out_2(acc_a2), .acc_out_3(acc_a3),
    .valid_out(vo_a)
  );

  top_system #(.W(4), .ACC_W(8), .N_MACS(4)) dut_b (
    .clk(clk), .rst(rst), .start_weight(start_weight),
    .start_valid_pipeline(start_valid_pipeline), .start_layering(start_layering),
    .mode(mode), .clear_all(clear_all), .busy(busy_b),
    .acc_out_0(acc_b0), .acc_out_1(acc_b1), .acc_out_2(acc_b2), .acc_out_3(acc_b3),
    .valid_out(vo_b)
  );

  int checks = 0;
  int errors = 0;
  int mw   [2][4];   // model weights per instance
  int macc [2][4];   // model accumulators per instance

  function automatic int wbits(int cfg); return (cfg == 0) ? 8 : 4; endfunction
  function automatic int abits(int cfg); return (cfg == 0) ? 16 : 8; endfunction

  // Reinterpret the low 'bits' bits of v as a signed number.
  function automatic int fit(int v, int bits);
    int m;
    m = v & ((1 << bits) - 1);
    if (m >= (1 << (bits - 1))) m = m - (1 << bits);
    return m;
  endfunction

  function automatic int acc_add(int acc, int prod, int bits);
    int s;
    s = acc + prod;
`ifdef ACC_SAT_EN
    if (s > (1 << (bits - 1)) - 1) return (1 << (bits - 1)) - 1;
    if (s < -(1 << (bits - 1)))    return -(1 << (bits - 1));
    return s;
`else
    return fit(s, bits);
`endif
  endfunction

  function automatic logic signed [63:0] acc_of(int cfg, int i);
    if (cfg == 0) begin
      case (i)
        0: return 64'(acc_a0);
        1: return 64'(acc_a1);
        2: return 64'(acc_a2);
        default: return 64'(acc_a3);
      endcase
    end else begin
      case (i)
        0: return 64'(acc_b0);
        1: return 64'(acc_b1);
        2: return 64'(acc_b2);
        default: return 64'(acc_b3);
      endcase
    end
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag, input logic exp_busy, input logic [3:0] exp_vo);
    chk({tag, "_busy_a"}, 64'(busy_a), longint'(exp_busy));
    chk({tag, "_busy_b"}, 64'(busy_b), longint'(exp_busy));
    chk({tag, "_vo_a"},   64'(vo_a),   longint'(exp_vo));
    chk({tag, "_vo_b"},   64'(vo_b),   longint'(exp_vo));
  endtask

  task automatic chk_acc_all(input string tag);
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 4; i++)
        chk($sformatf("%s_cfg%0d_acc%0d", tag, c, i), acc_of(c, i), longint'(macc[c][i]));
  endtask

  // Random start requests while busy; they must have no effect.
  task automatic noise(input bit en);
    if (en) begin
      start_weight         = 1'($urandom);
      start_valid_pipeline = 1'($urandom);
      start_layering       = 1'($urandom);
      mode                 = 3'($urandom);
    end else begin
      start_weight         = 1'b0;
      start_valid_pipeline = 1'b0;
      start_layering       = 1'b0;
    end
  endtask

  task automatic pulse_start(input bit sw, input bit sv, input bit sl, input logic [2:0] m);
    start_weight         = sw;
    start_valid_pipeline = sv;
    start_layering       = sl;
    mode                 = m;
    tick();
    noise(1'b0);
  endtask

  task automatic run_load(input logic [2:0] m, input bit extras);
    pulse_start(1'b1, extras, extras, m);
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 4; i++) mw[c][i] = fit(int'(m) + i + 1, wbits(c));
    for (int k = 0; k < 4; k++) begin
      chk_status("load", 1'b1, 4'b0000);
      noise(1'b1);
      tick();
    end
    noise(1'b0);
    chk_status("load_done", 1'b0, 4'b0000);
    chk_acc_all("load_hold");
  endtask

  task automatic run_valid(input bit with_layer);
    int fin [2][4];
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 4; i++) begin
        fin[c][i] = 0;
        for (int k = 0; k < 4; k++)
          fin[c][i] = acc_add(fin[c][i], (k + 1) * mw[c][i], abits(c));
      end
    pulse_start(1'b0, 1'b1, with_layer, 3'($urandom));
    for (int rc = 0; rc < 8; rc++) begin
      chk_status($sformatf("run_v_rc%0d", rc), 1'b1, (rc >= 4) ? 4'(1 << (rc - 4)) : 4'b0000);
      if (rc >= 4)
        for (int c = 0; c < 2; c++)
          chk($sformatf("run_v_cfg%0d_acc%0d", c, rc - 4), acc_of(c, rc - 4),
              longint'(fin[c][rc - 4]));
      noise(1'b1);
      tick();
    end
    noise(1'b0);
    macc = fin;
    chk_status("run_v_done", 1'b0, 4'b0000);
    chk_acc_all("run_v_done");
  endtask

  task automatic run_layer();
    int a0, a1;
    for (int c = 0; c < 2; c++) begin
      a0 = fit(macc[c][0], wbits(c));
      a1 = fit(macc[c][1], wbits(c));
      for (int i = 2; i < 4; i++)
        macc[c][i] = acc_add(acc_add(0, a0 * mw[c][i], abits(c)), a1 * mw[c][i], abits(c));
    end
    pulse_start(1'b0, 1'b0, 1'b1, 3'($urandom));
    for (int rc = 0; rc < 4; rc++) begin
      chk_status($sformatf("run_l_rc%0d", rc), 1'b1,
                 (rc == 2) ? 4'b0100 : (rc == 3) ? 4'b1000 : 4'b0000);
      if (rc >= 2)
        for (int c = 0; c < 2; c++)
          chk($sformatf("run_l_cfg%0d_acc%0d", c, rc), acc_of(c, rc), longint'(macc[c][rc]));
      noise(1'b1);
      tick();
    end
    noise(1'b0);
    chk_status("run_l_done", 1'b0, 4'b0000);
    chk_acc_all("run_l_done");
  endtask

  task automatic do_clear();
    clear_all            = 1'b1;
    start_valid_pipeline = 1'($urandom);
    tick();
    clear_all            = 1'b0;
    start_valid_pipeline = 1'b0;
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 4; i++) macc[c][i] = 0;
    chk_status("clear", 1'b0, 4'b0000);
    chk_acc_all("clear");
  endtask

  task automatic abort_valid(input int at);
    pulse_start(1'b0, 1'b1, 1'b0, 3'd0);
    for (int rc = 0; rc < at; rc++) begin
      chk_status("pre_abort", 1'b1, (rc >= 4) ? 4'(1 << (rc - 4)) : 4'b0000);
      tick();
    end
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 4; i++) macc[c][i] = 0;
    chk_acc_all("abort");
    for (int k = 0; k < 9; k++) begin
      chk_status("post_abort", 1'b0, 4'b0000);
      tick();
    end
    chk_acc_all("post_abort");
  endtask

  task automatic reset_mid();
    pulse_start(1'b1, 1'b0, 1'b0, 3'd5);
    tick();
    tick();
    rst                  = 1'b1;
    start_weight         = 1'b1;
    start_valid_pipeline = 1'b1;
    tick();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 4; i++) begin
        macc[c][i] = 0;
        mw[c][i]   = 0;
      end
    chk_status("rst_mid", 1'b0, 4'b0000);
    chk_acc_all("rst_mid");
    tick();
    rst = 1'b0;
    noise(1'b0);
    tick();
    chk_status("rst_after", 1'b0, 4'b0000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_all = 1'b0;
    mode = 3'd0;
    noise(1'b0);
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 4; i++) begin
        macc[c][i] = 0;
        mw[c][i]   = 0;
      end
    chk_status("reset", 1'b0, 4'b0000);
    chk_acc_all("reset");

    // Worked example from the requirements on the default instance.
    run_load(3'd1, 1'b0);
    run_valid(1'b0);
    chk("ex_acc0", 64'(acc_a0), 20);
    chk("ex_acc3", 64'(acc_a3), 50);
    run_layer();
    chk("ex_l_acc2", 64'(acc_a2), 200);
    chk("ex_l_acc3", 64'(acc_a3), 250);
    chk("ex_l_acc0", 64'(acc_a0), 20);
    chk("ex_l_acc1", 64'(acc_a1), 30);

    // Clear keeps weights: a rerun must reproduce the same pass.
    do_clear();
    run_valid(1'b0);
    chk("rerun_acc1", 64'(acc_a1), 30);

    // All starts at once -> load; valid+layer together -> valid pass.
    run_load(3'd7, 1'b1);
    run_valid(1'b1);
    chk("m7_acc0", 64'(acc_a0), 80);
    chk("m7_acc3", 64'(acc_a3), 110);
    run_layer();
    chk("m7_l_acc2", 64'(acc_a2), 1700);
    chk("m7_l_acc3", 64'(acc_a3), 1870);

    abort_valid(5);
    reset_mid();
    run_valid(1'b0);
    run_load(3'd3, 1'b0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0:       run_load(3'($urandom), 1'($urandom));
        1, 2:    run_valid(1'($urandom));
        3:       run_layer();
        4:       do_clear();
        default: abort_valid(int'($urandom_range(0, 7)));
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/top_system.md
TOP_SYSTEM -- requirements
Module: top_system

Interface
REQ-001 SHALL have parameter W, default 8: signed activation and weight width.
REQ-002 SHALL have parameter ACC_W, default 16: signed accumulator width.
REQ-003 SHALL have parameter N_MACS, default 4: MAC chain length; the acc_out_0..3 ports fix it at 4.
REQ-004 SHALL have one clock; reset is synchronous and active-high (ports clk, rst).
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 start_weight  input  1  one-cycle request to load weights.
REQ-008 start_valid_pipeline  input  1  one-cycle request to run the 4-sample MAC pass.
REQ-009 start_layering  input  1  one-cycle request to run the second-layer pass.
REQ-010 mode  input  3  weight-set selector, sampled on weight-load accept.
REQ-011 clear_all  input  1  synchronous clear/abort.
REQ-012 busy  output  1  high while any operation is in progress.
REQ-013 acc_out_0..acc_out_3  output  ACC_W signed  registered accumulator of MAC 0..3.
REQ-014 valid_out  output  N_MACS  bit i pulses one cycle when acc_out_i is final.

Function
REQ-015 States: IDLE, LOAD_W, RUN_V, RUN_L. Starts are accepted only in IDLE with busy low and are ignored otherwise.
REQ-016 Simultaneous starts in IDLE: priority start_weight > start_valid_pipeline > start_layering.
REQ-017 LOAD_W: on accept, latch mode. On the next 4 cycles, load weight w[i] = mode+i+1 into MAC i, i = 0..3, one MAC per cycle, as W-bit signed. Then return to IDLE.
REQ-018 RUN_V: on the accept edge, clear all four accumulators. Run cycle 0 is the first cycle after accept. Activation x_k = k+1 (k = 0..3) enters MAC0 at run cycle k. MAC i sees x_k at run cycle k+i via a one-register-per-stage systolic shift.
REQ-019 RUN_V: MAC i accumulates x_k*w[i]. valid_out[i] is high exactly during run cycle 4+i. Accumulators hold their value after the last sample.
REQ-020 RUN_L: on the accept edge, clear MAC2 and MAC3 only. MAC0 and MAC1 keep their values.
REQ-021 RUN_L: activations a0 = acc_out_0[W-1:0] and a1 = acc_out_1[W-1:0] are captured on the accept edge. a0 enters MAC2 at run cycle 0 and a1 at run cycle 1; MAC3 sees each one cycle later.
REQ-022 RUN_L: valid_out[2] is high exactly during run cycle 2 and valid_out[3] exactly during run cycle 3.
REQ-023 busy is high from the cycle after accept through the cycle of the final valid_out pulse or final weight load, and low in the following cycle, which is IDLE.
REQ-024 Arithmetic: signed W x W product, sign-extended to ACC_W, then added. Wrap modulo 2^ACC_W unless REQ-030 applies.
REQ-025 clear_all has priority over everything except rst. On the next edge: all accumulators = 0, valid_out = 0, state = IDLE, busy = 0. Weights and latched mode are retained. An in-flight operation is aborted.
REQ-026 Only the MACs being computed change; acc_out ports are stable otherwise.

Reset
REQ-027 rst SHALL set acc_out_0..3 = 0, valid_out = 0, busy = 0, all weights = 0, latched mode = 0, pipeline registers = 0 and state = IDLE, and SHALL override every other input.
REQ-028 rst asserted mid-operation SHALL abort on the same edge; starts held during rst are discarded.

Configuration
REQ-029 Macro ACC_SAT_EN SHALL select accumulator overflow behaviour.
REQ-030 With ACC_SAT_EN defined, each accumulate saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-031 Without ACC_SAT_EN, each accumulate wraps two's-complement.

Verification
REQ-032 Reset, then start_weight with mode=1 -> busy high 4 cycles; weights become 2,3,4,5.
REQ-033 After REQ-032, start_valid_pipeline -> valid_out[0] at run cycle 4 with acc_out_0=20, then one pulse per cycle. Final acc = [20,30,40,50]; busy low the cycle after valid_out[3].
REQ-034 Then start_layering -> valid_out[2] at run cycle 2 with acc_out_2=200, valid_out[3] next cycle with acc_out_3=250. acc_out_0/1 stay 20/30.
REQ-035 clear_all pulse -> all acc_out = 0 on the next edge and busy = 0. A clear_all during RUN_V aborts it with no further valid_out pulses.
REQ-036 start_valid_pipeline and start_layering asserted together in IDLE -> valid pass runs. Any start while busy is ignored, with no change to timing or results.
REQ-037 mode=7 gives weights 8..11 and a first-pass result of [80,90,100,110]. Layering then gives a0=80, a1=90, which yields acc_out_2 = 170*10 = 1700 and acc_out_3 = 1870. Repeat with W=4, ACC_W=8: under ACC_SAT_EN results clamp at 127; without it results wrap.
